// File: rtl/alu_exec.sv
// Integer/branch execution stage for RV32I ops, feeding the CDB through a one-entry result register.
// The operation encodings live in alu_exec_pkg so the reservation station and the bench share them.
package alu_exec_pkg;
    localparam int OP_W = 6;

    localparam logic [OP_W-1:0] OP_NOP   = 6'd0;
    localparam logic [OP_W-1:0] OP_ADD   = 6'd1;
    localparam logic [OP_W-1:0] OP_SUB   = 6'd2;
    localparam logic [OP_W-1:0] OP_SLL   = 6'd3;
    localparam logic [OP_W-1:0] OP_SLT   = 6'd4;
    localparam logic [OP_W-1:0] OP_SLTU  = 6'd5;
    localparam logic [OP_W-1:0] OP_XOR   = 6'd6;
    localparam logic [OP_W-1:0] OP_SRL   = 6'd7;
    localparam logic [OP_W-1:0] OP_SRA   = 6'd8;
    localparam logic [OP_W-1:0] OP_OR    = 6'd9;
    localparam logic [OP_W-1:0] OP_AND   = 6'd10;
    localparam logic [OP_W-1:0] OP_ADDI  = 6'd11;
    localparam logic [OP_W-1:0] OP_SLLI  = 6'd12;
    localparam logic [OP_W-1:0] OP_SLTI  = 6'd13;
    localparam logic [OP_W-1:0] OP_SLTIU = 6'd14;
    localparam logic [OP_W-1:0] OP_XORI  = 6'd15;
    localparam logic [OP_W-1:0] OP_SRLI  = 6'd16;
    localparam logic [OP_W-1:0] OP_SRAI  = 6'd17;
    localparam logic [OP_W-1:0] OP_ORI   = 6'd18;
    localparam logic [OP_W-1:0] OP_ANDI  = 6'd19;
    localparam logic [OP_W-1:0] OP_LUI   = 6'd20;
    localparam logic [OP_W-1:0] OP_AUIPC = 6'd21;
    localparam logic [OP_W-1:0] OP_JAL   = 6'd22;
    localparam logic [OP_W-1:0] OP_JALR  = 6'd23;
    localparam logic [OP_W-1:0] OP_BEQ   = 6'd24;
    localparam logic [OP_W-1:0] OP_BNE   = 6'd25;
    localparam logic [OP_W-1:0] OP_BLT   = 6'd26;
    localparam logic [OP_W-1:0] OP_BGE   = 6'd27;
    localparam logic [OP_W-1:0] OP_BLTU  = 6'd28;
    localparam logic [OP_W-1:0] OP_BGEU  = 6'd29;
    localparam logic [OP_W-1:0] OP_LW    = 6'd32;
    localparam logic [OP_W-1:0] OP_SW    = 6'd37;
endpackage

module alu_exec
    import alu_exec_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ROB_W  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [OP_W-1:0]   in_op,
    input  logic [DATA_W-1:0] in_Vj,
    input  logic [DATA_W-1:0] in_Vk,
    input  logic [DATA_W-1:0] in_imm,
    input  logic [DATA_W-1:0] in_pc,
    input  logic [ROB_W-1:0]  in_rob_tag,
    input  logic              in_flush,
    input  logic              in_cdb_grant,
    output logic              out_busy,
    output logic              out_cdb_valid,
    output logic [ROB_W-1:0]  out_cdb_rob_tag,
    output logic [DATA_W-1:0] out_cdb_data,
    output logic              out_branch_taken,
    output logic [DATA_W-1:0] out_branch_target
);
    typedef enum logic [3:0] {
        FN_ADD, FN_SUB, FN_SLL, FN_SLT, FN_SLTU,
        FN_XOR, FN_SRL, FN_SRA, FN_OR, FN_AND
    } alu_fn_t;

    logic              valid_reg;
    logic [ROB_W-1:0]  tag_reg;
    logic [DATA_W-1:0] data_reg;
    logic              taken_reg;
    logic [DATA_W-1:0] target_reg;

    logic              accept;
    alu_fn_t           alu_fn;
    logic              use_alu;
    logic              use_imm;
    logic [DATA_W-1:0] opb;
    logic [DATA_W-1:0] alu_res;
    logic [DATA_W-1:0] data_next;
    logic              taken_next;
    logic [DATA_W-1:0] target_next;
    logic [DATA_W-1:0] pc_imm;
    logic [DATA_W-1:0] pc_4;

    assign out_busy = valid_reg & ~in_cdb_grant;
    assign accept   = in_valid & ~out_busy & ~in_flush & (in_rob_tag != '0);
    assign opb      = use_imm ? in_imm : in_Vk;
    assign pc_imm   = in_pc + in_imm;
    assign pc_4     = in_pc + DATA_W'(4);

    // R and I forms share one ALU; decode selects the function and second operand.
    always_comb begin
        alu_fn  = FN_ADD;
        use_alu = 1'b0;
        use_imm = 1'b0;
        case (in_op)
            OP_ADD:   begin use_alu = 1'b1; alu_fn = FN_ADD;  end
            OP_SUB:   begin use_alu = 1'b1; alu_fn = FN_SUB;  end
            OP_SLL:   begin use_alu = 1'b1; alu_fn = FN_SLL;  end
            OP_SLT:   begin use_alu = 1'b1; alu_fn = FN_SLT;  end
            OP_SLTU:  begin use_alu = 1'b1; alu_fn = FN_SLTU; end
            OP_XOR:   begin use_alu = 1'b1; alu_fn = FN_XOR;  end
            OP_SRL:   begin use_alu = 1'b1; alu_fn = FN_SRL;  end
            OP_SRA:   begin use_alu = 1'b1; alu_fn = FN_SRA;  end
            OP_OR:    begin use_alu = 1'b1; alu_fn = FN_OR;   end
            OP_AND:   begin use_alu = 1'b1; alu_fn = FN_AND;  end
            OP_ADDI:  begin use_alu = 1'b1; use_imm = 1'b1; alu_fn = FN_ADD;  end
            OP_SLLI:  begin use_alu = 1'b1; use_imm = 1'b1; alu_fn = FN_SLL;  end
            OP_SLTI:  begin use_alu = 1'b1; use_imm = 1'b1; alu_fn = FN_SLT;  end
            OP_SLTIU: begin use_alu = 1'b1; use_imm = 1'b1; alu_fn = FN_SLTU; end
            OP_XORI:  begin use_alu = 1'b1; use_imm = 1'b1; alu_fn = FN_XOR;  end
            OP_SRLI:  begin use_alu = 1'b1; use_imm = 1'b1; alu_fn = FN_SRL;  end
            OP_SRAI:  begin use_alu = 1'b1; use_imm = 1'b1; alu_fn = FN_SRA;  end
            OP_ORI:   begin use_alu = 1'b1; use_imm = 1'b1; alu_fn = FN_OR;   end
            OP_ANDI:  begin use_alu = 1'b1; use_imm = 1'b1; alu_fn = FN_AND;  end
            default:  ;
        endcase
    end

    always_comb begin
        alu_res = '0;
        case (alu_fn)
            FN_ADD:  alu_res = in_Vj + opb;
            FN_SUB:  alu_res = in_Vj - opb;
            FN_SLL:  alu_res = in_Vj << opb[4:0];
            FN_SLT:  alu_res = DATA_W'($signed(in_Vj) < $signed(opb));
            FN_SLTU: alu_res = DATA_W'(in_Vj < opb);
            FN_XOR:  alu_res = in_Vj ^ opb;
            FN_SRL:  alu_res = in_Vj >> opb[4:0];
            FN_SRA:  alu_res = $unsigned($signed(in_Vj) >>> opb[4:0]);
            FN_OR:   alu_res = in_Vj | opb;
            FN_AND:  alu_res = in_Vj & opb;
            default: alu_res = '0;
        endcase
    end

    // Memory and unknown ops fall through with zeros so their ROB entry still retires.
    always_comb begin
        data_next   = '0;
        taken_next  = 1'b0;
        target_next = '0;
        case (in_op)
            OP_LUI:   data_next = in_imm;
            OP_AUIPC: data_next = pc_imm;
            OP_JAL: begin
                data_next   = pc_4;
                taken_next  = 1'b1;
                target_next = pc_imm;
            end
            OP_JALR: begin
                data_next   = pc_4;
                taken_next  = 1'b1;
                target_next = (in_Vj + in_imm) & ~DATA_W'(1);
            end
            OP_BEQ:  begin taken_next = (in_Vj == in_Vk); target_next = pc_imm; end
            OP_BNE:  begin taken_next = (in_Vj != in_Vk); target_next = pc_imm; end
            OP_BLT:  begin taken_next = ($signed(in_Vj) <  $signed(in_Vk)); target_next = pc_imm; end
            OP_BGE:  begin taken_next = ($signed(in_Vj) >= $signed(in_Vk)); target_next = pc_imm; end
            OP_BLTU: begin taken_next = (in_Vj <  in_Vk); target_next = pc_imm; end
            OP_BGEU: begin taken_next = (in_Vj >= in_Vk); target_next = pc_imm; end
            default: if (use_alu) data_next = alu_res;
        endcase
    end

    // Priority: reset, flush, accept (which also covers grant-and-replace), then grant-to-empty.
    always_ff @(posedge clk) begin
        if (!rst) begin
            valid_reg  <= 1'b0;
            tag_reg    <= '0;
            data_reg   <= '0;
            taken_reg  <= 1'b0;
            target_reg <= '0;
        end else if (in_flush) begin
            valid_reg <= 1'b0;
        end else if (accept) begin
            valid_reg  <= 1'b1;
            tag_reg    <= in_rob_tag;
            data_reg   <= data_next;
            taken_reg  <= taken_next;
            target_reg <= target_next;
        end else if (valid_reg && in_cdb_grant) begin
            valid_reg <= 1'b0;
        end
    end

    assign out_cdb_valid     = valid_reg;
    assign out_cdb_rob_tag   = tag_reg;
    assign out_cdb_data      = data_reg;
    assign out_branch_taken  = taken_reg;
    assign out_branch_target = target_reg;
endmodule

// File: tb/tb_alu_exec.sv
// Directed bench for alu_exec: hand-computed vectors covering ALU, branch, hold, flush and reset behaviour.
module tb_alu_exec;
    import alu_exec_pkg::*;

    logic              clk = 1'b0;
    logic              rst;
    logic              in_valid;
    logic [OP_W-1:0]   in_op;
    logic [31:0]       in_Vj, in_Vk, in_imm, in_pc;
    logic [3:0]        in_rob_tag;
    logic              in_flush;
    logic              in_cdb_grant;
    logic              out_busy;
    logic              out_cdb_valid;
    logic [3:0]        out_cdb_rob_tag;
    logic [31:0]       out_cdb_data;
    logic              out_branch_taken;
    logic [31:0]       out_branch_target;

    int checks = 0;
    int errors = 0;

    alu_exec #(.DATA_W(32), .ROB_W(4)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_op(in_op),
        .in_Vj(in_Vj), .in_Vk(in_Vk), .in_imm(in_imm), .in_pc(in_pc),
        .in_rob_tag(in_rob_tag), .in_flush(in_flush), .in_cdb_grant(in_cdb_grant),
        .out_busy(out_busy), .out_cdb_valid(out_cdb_valid),
        .out_cdb_rob_tag(out_cdb_rob_tag), .out_cdb_data(out_cdb_data),
        .out_branch_taken(out_branch_taken), .out_branch_target(out_branch_target)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end else begin
            $display("ok   %s: 0x%08h", tag, got);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [OP_W-1:0] op, input logic [31:0] vj, input logic [31:0] vk,
                         input logic [31:0] imm, input logic [31:0] pc, input logic [3:0] tag);
        in_valid   = 1'b1;
        in_op      = op;
        in_Vj      = vj;
        in_Vk      = vk;
        in_imm     = imm;
        in_pc      = pc;
        in_rob_tag = tag;
    endtask

    task automatic check_res(input string name, input logic [3:0] tag, input logic [31:0] data,
                             input logic taken, input logic [31:0] target);
        check({name, ".valid"},  32'(out_cdb_valid), 32'd1);
        check({name, ".tag"},    32'(out_cdb_rob_tag), 32'(tag));
        check({name, ".data"},   out_cdb_data, data);
        check({name, ".taken"},  32'(out_branch_taken), 32'(taken));
        check({name, ".target"}, out_branch_target, target);
        check({name, ".busy"},   32'(out_busy), 32'd0);
    endtask

    initial begin
        rst = 1'b0; in_valid = 1'b0; in_op = OP_NOP; in_Vj = '0; in_Vk = '0;
        in_imm = '0; in_pc = '0; in_rob_tag = '0; in_flush = 1'b0; in_cdb_grant = 1'b0;
        step(); step();
        check("rst.valid", 32'(out_cdb_valid), 32'd0);
        check("rst.tag",   32'(out_cdb_rob_tag), 32'd0);
        check("rst.data",  out_cdb_data, 32'd0);
        check("rst.busy",  32'(out_busy), 32'd0);
        rst = 1'b1;
        step();

        // Back-to-back stream with grant held high: each op broadcasts the cycle after issue.
        in_cdb_grant = 1'b1;
        drive(OP_ADD, 32'd5, 32'hFFFF_FFFF, 32'd0, 32'd0, 4'd3);          step();
        check_res("add", 4'd3, 32'd4, 1'b0, 32'd0);
        drive(OP_SRA, 32'h8000_0000, 32'h24, 32'd0, 32'd0, 4'd1);         step();
        check_res("sra", 4'd1, 32'hF800_0000, 1'b0, 32'd0);
        drive(OP_SLTU, 32'd1, 32'hFFFF_FFFF, 32'd0, 32'd0, 4'd2);         step();
        check_res("sltu", 4'd2, 32'd1, 1'b0, 32'd0);
        drive(OP_SLT, 32'd1, 32'hFFFF_FFFF, 32'd0, 32'd0, 4'd3);          step();
        check_res("slt", 4'd3, 32'd0, 1'b0, 32'd0);
        drive(OP_BLT, 32'hFFFF_FFFF, 32'd0, 32'h20, 32'h100, 4'd4);       step();
        check_res("blt", 4'd4, 32'd0, 1'b1, 32'h120);
        drive(OP_JALR, 32'h203, 32'd0, 32'd2, 32'h40, 4'd5);              step();
        check_res("jalr", 4'd5, 32'h44, 1'b1, 32'h204);
        drive(OP_ADDI, 32'd10, 32'd99, 32'hFFFF_FFFD, 32'd0, 4'd6);       step();
        check_res("addi", 4'd6, 32'd7, 1'b0, 32'd0);
        drive(OP_SLLI, 32'h0000_0003, 32'd0, 32'h0000_0021, 32'd0, 4'd7); step();
        check_res("slli", 4'd7, 32'd6, 1'b0, 32'd0);
        drive(OP_LUI, 32'd7, 32'd7, 32'h1234_5000, 32'h80, 4'd8);         step();
        check_res("lui", 4'd8, 32'h1234_5000, 1'b0, 32'd0);
        drive(OP_AUIPC, 32'd0, 32'd0, 32'h2000, 32'h1000, 4'd9);          step();
        check_res("auipc", 4'd9, 32'h3000, 1'b0, 32'd0);
        drive(OP_JAL, 32'd0, 32'd0, 32'h10, 32'h200, 4'd10);              step();
        check_res("jal", 4'd10, 32'h204, 1'b1, 32'h210);
        drive(OP_BGE, 32'hFFFF_FFFF, 32'd0, 32'h8, 32'h300, 4'd11);       step();
        check_res("bge_nt", 4'd11, 32'd0, 1'b0, 32'h308);
        drive(OP_BLTU, 32'd1, 32'hFFFF_FFFF, 32'h10, 32'h0, 4'd12);       step();
        check_res("bltu", 4'd12, 32'd0, 1'b1, 32'h10);
        drive(OP_LW, 32'd4, 32'd4, 32'd4, 32'h40, 4'd13);                 step();
        check_res("unknown", 4'd13, 32'd0, 1'b0, 32'd0);

        // Tag 0 is consumed without producing a broadcast.
        drive(OP_ADD, 32'd1, 32'd1, 32'd0, 32'd0, 4'd0);                  step();
        check("tag0.valid", 32'(out_cdb_valid), 32'd0);
        in_valid = 1'b0;
        step();

        // Hold with grant low: busy asserted, outputs frozen, issues ignored.
        in_cdb_grant = 1'b0;
        drive(OP_ADD, 32'd1, 32'd2, 32'd0, 32'd0, 4'd5);                  step();
        check("hold.busy", 32'(out_busy), 32'd1);
        for (int i = 0; i < 3; i++) begin
            drive(OP_OR, 32'd100, 32'd1, 32'd0, 32'd0, 4'd9);             step();
            check("hold.tag",   32'(out_cdb_rob_tag), 32'd5);
            check("hold.data",  out_cdb_data, 32'd3);
            check("hold.valid", 32'(out_cdb_valid), 32'd1);
            check("hold.busy",  32'(out_busy), 32'd1);
        end
        in_cdb_grant = 1'b1;
        drive(OP_SUB, 32'd10, 32'd4, 32'd0, 32'd0, 4'd6);
        #1;
        check("grant.busy_comb", 32'(out_busy), 32'd0);
        step();
        check_res("replace", 4'd6, 32'd6, 1'b0, 32'd0);
        in_valid = 1'b0;                                                  step();
        check("drain.valid", 32'(out_cdb_valid), 32'd0);

        // Flush while full with a same-edge issue that would otherwise be accepted.
        in_cdb_grant = 1'b0;
        drive(OP_XOR, 32'hF0, 32'h0F, 32'd0, 32'd0, 4'd8);                step();
        check("pre_flush.valid", 32'(out_cdb_valid), 32'd1);
        in_cdb_grant = 1'b1;
        in_flush = 1'b1;
        drive(OP_ADD, 32'd1, 32'd1, 32'd0, 32'd0, 4'd9);                  step();
        check("flush.valid", 32'(out_cdb_valid), 32'd0);
        in_flush = 1'b0;
        in_valid = 1'b0;                                                  step();
        check("post_flush.valid", 32'(out_cdb_valid), 32'd0);

        // Reset in the middle of a hold drops the held jump result.
        in_cdb_grant = 1'b0;
        drive(OP_JAL, 32'd0, 32'd0, 32'h8, 32'h300, 4'd4);                step();
        check_res_hold: begin
            check("hold2.data",   out_cdb_data, 32'h304);
            check("hold2.taken",  32'(out_branch_taken), 32'd1);
            check("hold2.target", out_branch_target, 32'h308);
        end
        in_valid = 1'b0;                                                  step();
        rst = 1'b0;                                                       step();
        check("mid_rst.valid",  32'(out_cdb_valid), 32'd0);
        check("mid_rst.tag",    32'(out_cdb_rob_tag), 32'd0);
        check("mid_rst.data",   out_cdb_data, 32'd0);
        check("mid_rst.taken",  32'(out_branch_taken), 32'd0);
        check("mid_rst.target", out_branch_target, 32'd0);
        check("mid_rst.busy",   32'(out_busy), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
